// File: rtl/spi_sram_burst_master_pkg.sv
// Shared types and constants for the SPI SRAM burst master.
// Command opcodes follow 23LC-style serial SRAMs.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, TURN, DATA, GAP} spi_mst_state_t;

  // Address bytes go out MSB first; idx 2 selects addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [ADDR_BITS-1:0] a, input logic [1:0] idx);
    case (idx)
      2'd2:    return a[23:16];
      2'd1:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_sram_burst_master_if.sv
// CPU request/data handshake plus SPI pins of the burst master.
// Request: accepted on the posedge where req_valid && req_ready; wr_ready/rd_valid are one-cycle strobes with no back-pressure.
interface spi_sram_burst_master_if #(
  parameter int BURST_W = 4
);
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_wr;
  logic [spi_sram_pkg::ADDR_BITS-1:0] req_addr;
  logic [BURST_W-1:0]               req_len;
  logic                             wr_ready;
  logic [7:0]                       wr_data;
  logic                             rd_valid;
  logic [7:0]                       rd_data;
  logic                             busy;
  logic                             cs_n;
  logic                             mosi;
  logic                             miso;

  modport master (
    input  req_valid, req_wr, req_addr, req_len, wr_data, miso,
    output req_ready, wr_ready, rd_valid, rd_data, busy, cs_n, mosi
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_len, wr_data, miso,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, cs_n, mosi
  );
endinterface

// File: rtl/spi_sram_burst_master_bit_shifter.sv
// 8-bit MSB-first serializer with a serial-in capture path.
// cap presents the 7 captured bits plus the live input, i.e. the full byte on its last bit.
module spi_bit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       sample,
  input  logic       sin,
  output logic       sout,
  output logic [7:0] cap
);
  logic [7:0] sreg;
  logic [6:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= 8'h00;
      hist <= 7'h00;
    end else begin
      if (load)       sreg <= load_data;
      else if (shift) sreg <= {sreg[6:0], 1'b0};
      if (sample)     hist <= cap[6:0];
    end
  end

  assign sout = sreg[7];
  assign cap  = {hist, sin};
endmodule

// File: rtl/spi_sram_burst_master.sv
// CPU-side SPI master issuing 23LC-style READ/WRITE bursts of 1..2**BURST_W bytes.
// The SPI bit clock is clk; one bit per cycle, MSB first.
module spi_sram_burst_master
  import spi_sram_pkg::*;
#(
  parameter int BURST_W = 4,
  parameter int RD_LAT  = 1,
  parameter int CS_GAP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_sram_burst_master_if.master bus,
  output spi_mst_state_t          state
);
  localparam logic [2:0] TURN_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0] GAP_LAST  = 3'(CS_GAP - 1);

  spi_mst_state_t cur_state, nxt_state;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [BURST_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [1:0]         addr_idx, addr_idx_nxt;
  logic               wr_mode;
  logic [23:0]        addr;
  logic [BURST_W-1:0] len;
  logic               accept, byte_end;
  logic               sh_load, sh_shift, sh_sample;
  logic [7:0]         sh_data, cap;
  logic               wr_ready_nxt, rd_valid_nxt, cs_n_nxt, busy_nxt;

  assign bus.req_ready = (cur_state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign byte_end      = (bit_cnt == 3'd7);
  assign state         = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: if (accept) nxt_state = CMD;
      CMD:  if (byte_end) nxt_state = ADDR;
      ADDR: if (byte_end && addr_idx == 2'd0) nxt_state = (!wr_mode && RD_LAT != 0) ? TURN : DATA;
      TURN: if (bit_cnt == TURN_LAST) nxt_state = DATA;
      DATA: if (byte_end && byte_cnt == '0) nxt_state = GAP;
      GAP:  if (bit_cnt == GAP_LAST) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Byte boundaries reload the shifter; write strobes fire one bit early so wr_data lands on the reload edge.
  always_comb begin
    bit_cnt_nxt  = bit_cnt + 3'd1;
    byte_cnt_nxt = byte_cnt;
    addr_idx_nxt = addr_idx;
    sh_load      = 1'b0;
    sh_data      = 8'h00;
    sh_shift     = 1'b0;
    sh_sample    = 1'b0;
    wr_ready_nxt = 1'b0;
    rd_valid_nxt = 1'b0;
    cs_n_nxt     = !(nxt_state inside {CMD, ADDR, TURN, DATA});
    busy_nxt     = (nxt_state != IDLE);
    case (cur_state)
      IDLE: begin
        bit_cnt_nxt = 3'd0;
        if (accept) begin
          sh_load = 1'b1;
          sh_data = bus.req_wr ? CMD_WRITE : CMD_READ;
        end
      end
      CMD: begin
        sh_shift = 1'b1;
        if (byte_end) begin
          sh_load      = 1'b1;
          sh_data      = addr_byte(addr, 2'd2);
          addr_idx_nxt = 2'd2;
        end
      end
      ADDR: begin
        sh_shift = 1'b1;
        if (wr_mode && addr_idx == 2'd0 && bit_cnt == 3'd6) wr_ready_nxt = 1'b1;
        if (byte_end) begin
          sh_load = 1'b1;
          if (addr_idx != 2'd0) begin
            addr_idx_nxt = addr_idx - 2'd1;
            sh_data      = addr_byte(addr, addr_idx - 2'd1);
          end else begin
            byte_cnt_nxt = len;
            sh_data      = wr_mode ? bus.wr_data : 8'h00;
          end
        end
      end
      TURN: if (bit_cnt == TURN_LAST) bit_cnt_nxt = 3'd0;
      DATA: begin
        sh_shift  = wr_mode;
        sh_sample = !wr_mode;
        if (wr_mode && bit_cnt == 3'd6 && byte_cnt != '0) wr_ready_nxt = 1'b1;
        if (byte_end) begin
          rd_valid_nxt = !wr_mode;
          sh_load      = 1'b1;
          sh_data      = (wr_mode && byte_cnt != '0) ? bus.wr_data : 8'h00;
          if (byte_cnt != '0) byte_cnt_nxt = byte_cnt - BURST_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= 3'd0;
      byte_cnt     <= '0;
      addr_idx     <= 2'd0;
      wr_mode      <= 1'b0;
      addr         <= 24'h0;
      len          <= '0;
      bus.cs_n     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.wr_ready <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 8'h00;
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      addr_idx     <= addr_idx_nxt;
      if (accept) begin
        wr_mode <= bus.req_wr;
        addr    <= bus.req_addr;
        len     <= bus.req_len;
      end
      bus.cs_n     <= cs_n_nxt;
      bus.busy     <= busy_nxt;
      bus.wr_ready <= wr_ready_nxt;
      bus.rd_valid <= rd_valid_nxt;
      if (rd_valid_nxt) bus.rd_data <= cap;
    end
  end

  spi_bit_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_data),
    .shift     (sh_shift),
    .sample    (sh_sample),
    .sin       (bus.miso),
    .sout      (bus.mosi),
    .cap       (cap)
  );
endmodule

// File: tb/tb_spi_sram_burst_master.sv
// Bench for spi_sram_burst_master: behavioural SPI SRAM slave on the pins, a byte-level
// memory model for expectations, and per-transaction checks of framing and strobes.
module tb_spi_sram_burst_master;
  import spi_sram_pkg::*;

  localparam int BURST_W = 4;
  localparam int RD_LAT  = 1;
  localparam int CS_GAP  = 1;

  logic clk, rst;
  spi_mst_state_t state;
  spi_sram_burst_master_if #(.BURST_W(BURST_W)) bus ();

  spi_sram_burst_master #(.BURST_W(BURST_W), .RD_LAT(RD_LAT), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [7:0]  model_mem [4096];
  logic [7:0]  slave_mem [4096];
  logic [7:0]  exp_q [$];
  logic [7:0]  wr_src [$];
  logic        stream [$];
  int          wr_pos_q [$];
  int          rd_pos_q [$];
  int          rel = 0, cs_low_len = 0, t_rise = 0, t_fall = 0;
  bit          in_txn = 0;
  logic        cur_wr;
  logic [23:0] cur_addr;
  logic [3:0]  cur_len;
  logic [7:0]  cur_data [16];
  int unsigned t_acc;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [23:0] a, input int k);
    return int'((a + 24'(k)) & 24'hFFF);
  endfunction

  function automatic logic [7:0] stream_byte(input int start);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], stream[start + i]};
    return b;
  endfunction

  function automatic logic [23:0] stream_addr();
    return {stream_byte(8), stream_byte(16), stream_byte(24)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- slave model + monitor + scoreboard ----------------
  always @(negedge clk) begin
    int j;
    if (rst) begin
      in_txn = 0;
      bus.miso = 1'b0;
      bus.wr_data = 8'h00;
    end else begin
      rel++;
      if (!bus.cs_n && !in_txn) begin
        in_txn = 1; rel = 0; cs_low_len = 0; t_fall = int'(cyc);
        stream.delete(); wr_pos_q.delete(); rd_pos_q.delete();
      end
      if (!bus.cs_n) begin
        stream.push_back(bus.mosi);
        cs_low_len++;
      end else if (in_txn) begin
        in_txn = 0;
        t_rise = int'(cyc);
      end
      if (bus.wr_ready) begin
        wr_pos_q.push_back(rel);
        bus.wr_data = (wr_src.size() > 0) ? wr_src.pop_front() : 8'h00;
      end
      if (bus.rd_valid) begin
        rd_pos_q.push_back(rel);
        check("rd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
      bus.miso = 1'b0;
      if (!bus.cs_n && stream.size() >= 32 && stream_byte(0) == CMD_READ && rel >= 32 + RD_LAT) begin
        j = rel - 32 - RD_LAT;
        bus.miso = slave_mem[idx(stream_addr(), j / 8)][7 - (j % 8)];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prepare(input logic wr, input logic [23:0] addr, input logic [3:0] len, input bit pattern);
    cur_wr = wr; cur_addr = addr; cur_len = len;
    for (int k = 0; k <= int'(len); k++) begin
      if (wr) begin
        cur_data[k] = pattern ? 8'(17 * (k + 1)) : 8'($urandom);
        wr_src.push_back(cur_data[k]);
        model_mem[idx(addr, k)] = cur_data[k];
      end else begin
        exp_q.push_back(model_mem[idx(addr, k)]);
      end
    end
  endtask

  task automatic start_txn(input logic wr, input logic [23:0] addr, input logic [3:0] len, input bit keep);
    int n = 0;
    bus.req_wr = wr; bus.req_addr = addr; bus.req_len = len; bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 300) begin step(); n++; end
    check("accept_timeout", 32'(n >= 300), 32'd0);
    t_acc = cyc;
    @(posedge clk);
    step();
    if (!keep) bus.req_valid = 1'b0;
    check("ready_drop", 32'(bus.req_ready), 32'd0);
    check("cs_fall", 32'(bus.cs_n), 32'd0);
    check("state_cmd", 32'(state), 32'(CMD));
  endtask

  task automatic finish_txn();
    int n = 0;
    int mism, exp_low;
    logic exp_bits [$];
    logic [7:0] eb [$];
    while (!bus.req_ready && n < 400) begin step(); n++; end
    check("done_timeout", 32'(n >= 400), 32'd0);
    exp_low = 32 + 8 * (int'(cur_len) + 1) + (cur_wr ? 0 : RD_LAT);
    check("ready_latency", cyc - t_acc, 32'(exp_low + CS_GAP + 1));
    check("cs_low_len", 32'(cs_low_len), 32'(exp_low));
    check("busy_idle", 32'(bus.busy), 32'd0);
    eb.push_back(cur_wr ? CMD_WRITE : CMD_READ);
    eb.push_back(cur_addr[23:16]);
    eb.push_back(cur_addr[15:8]);
    eb.push_back(cur_addr[7:0]);
    if (cur_wr) for (int k = 0; k <= int'(cur_len); k++) eb.push_back(cur_data[k]);
    foreach (eb[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(eb[i][b]);
    if (!cur_wr) repeat (RD_LAT + 8 * (int'(cur_len) + 1)) exp_bits.push_back(1'b0);
    mism = (stream.size() == exp_bits.size()) ? 0 : 1000;
    if (mism == 0) foreach (exp_bits[i]) if (stream[i] !== exp_bits[i]) mism++;
    check("mosi_stream", 32'(mism), 32'd0);
    check("wr_ready_count", 32'(wr_pos_q.size()), 32'(cur_wr ? int'(cur_len) + 1 : 0));
    check("rd_valid_count", 32'(rd_pos_q.size()), 32'(cur_wr ? 0 : int'(cur_len) + 1));
    mism = 0;
    foreach (wr_pos_q[i]) if (wr_pos_q[i] != 31 + 8 * i) mism++;
    foreach (rd_pos_q[i]) if (rd_pos_q[i] != 40 + RD_LAT + 8 * i) mism++;
    check("strobe_pos", 32'(mism), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("wr_src_drained", 32'(wr_src.size()), 32'd0);
    // The slave commits a write burst from what actually appeared on mosi.
    if (stream.size() >= 32 && stream_byte(0) == CMD_WRITE)
      for (int k = 0; k < (stream.size() - 32) / 8; k++)
        slave_mem[idx(stream_addr(), k)] = stream_byte(32 + 8 * k);
  endtask

  task automatic txn(input logic wr, input logic [23:0] addr, input logic [3:0] len, input bit pattern);
    prepare(wr, addr, len, pattern);
    start_txn(wr, addr, len, 1'b0);
    finish_txn();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, mism;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 24'h0; bus.req_len = 4'h0;
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = 8'($urandom);
      slave_mem[i] = model_mem[i];
    end
    step(); step();
    check("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    step();
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Single-byte read of a known value.
    model_mem[12'h400] = 8'hA9;
    slave_mem[12'h400] = 8'hA9;
    txn(1'b0, 24'h000400, 4'd0, 1'b0);
    // Full 16-byte read.
    txn(1'b0, 24'h000400, 4'd15, 1'b0);
    // Fixed-pattern write, then read it back through the slave.
    txn(1'b1, 24'h000200, 4'd3, 1'b1);
    txn(1'b0, 24'h000200, 4'd3, 1'b0);

    // Back-to-back reads with req_valid held high.
    prepare(1'b0, 24'h000010, 4'd2, 1'b0);
    start_txn(1'b0, 24'h000010, 4'd2, 1'b1);
    finish_txn();
    prepare(1'b0, 24'h000020, 4'd1, 1'b0);
    start_txn(1'b0, 24'h000020, 4'd1, 1'b0);
    check("b2b_gap", 32'(t_fall - t_rise), 32'(CS_GAP + 1));
    finish_txn();

    // Reset during bit cycle 20 of a read; no expectation is queued, so any rd_valid fails.
    start_txn(1'b0, 24'h000123, 4'd3, 1'b0);
    n = 0;
    while (!(in_txn && rel == 20) && n < 60) begin step(); n++; end
    check("abort_reach", 32'(n >= 60), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(bus.cs_n), 32'd1);
    check("abort_mosi", 32'(bus.mosi), 32'd0);
    check("abort_state", 32'(state), 32'(IDLE));
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_abort_ready", 32'(bus.req_ready), 32'd1);
    check("post_abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    txn(1'b0, 24'h000400, 4'd2, 1'b0);

    // Top-of-range address, two-byte write then read back.
    txn(1'b1, 24'hFFFFFF, 4'd1, 1'b0);
    txn(1'b0, 24'hFFFFFF, 4'd1, 1'b0);

    // Randomised mix.
    for (int t = 0; t < 10; t++)
      txn(1'($urandom_range(0, 1)), 24'($urandom), 4'($urandom_range(0, 15)), 1'b0);

    mism = 0;
    for (int i = 0; i < 4096; i++) if (slave_mem[i] !== model_mem[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
